// File: rtl/fft_mag_stream.sv
`default_nettype none
// ------------------------------------------------------------------
// fft_mag_stream : streaming |re,im| magnitude approximation with
//                  per-frame peak tracking.           Rev 1.0
// ------------------------------------------------------------------
module fft_mag_stream #(
  parameter  int DATA_W    = 12,
  parameter  int NUM_CH    = 2,
  parameter  int FRAME_LEN = 256,
  localparam int MAG_W     = DATA_W + 1,
  localparam int IDX_W     = $clog2(FRAME_LEN * NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*NUM_CH*DATA_W-1:0] in_data,
  input  logic [1:0]                 mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*MAG_W-1:0]    out_mag,
  output logic                       out_last,
  output logic                       peak_valid,
  output logic [MAG_W-1:0]           peak_mag,
  output logic [IDX_W-1:0]           peak_idx
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int LW    = NUM_CH * DATA_W;

  logic                    en;
  logic                    hs_out;
  logic                    v1_q, v2_q, v3_q;
  logic [1:0]              mode1_q, mode2_q;
  logic [LW-1:0]           a_d, b_d, a_q, b_q;
  logic [LW-1:0]           mx_d, mn_d, mx_q, mn_q;
  logic [NUM_CH*MAG_W-1:0] mag_d, out_mag_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [MAG_W-1:0]        run_mag_q, best_mag, peak_mag_q;
  logic [IDX_W-1:0]        run_idx_q, best_idx, peak_idx_q;
  logic                    peak_valid_q;

  // The whole pipeline stalls as one unit, so in-flight beats never move under backpressure.
  assign en        = !v3_q | out_ready;
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign out_mag   = out_mag_q;
  assign hs_out    = v3_q & out_ready;
  assign out_last  = (cnt_q == CNT_W'(FRAME_LEN - 1)) & v3_q;
  assign peak_valid = peak_valid_q;
  assign peak_mag   = peak_mag_q;
  assign peak_idx   = peak_idx_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [DATA_W-1:0] re, im, a, b;
    logic [MAG_W-1:0]  mxe, mne, mag;

    assign re = in_data[2*k*DATA_W +: DATA_W];
    assign im = in_data[(2*k+1)*DATA_W +: DATA_W];
    // Unsigned DATA_W result holds 2^(DATA_W-1) exactly for the most negative input.
    assign a_d[k*DATA_W +: DATA_W] = re[DATA_W-1] ? (~re + DATA_W'(1)) : re;
    assign b_d[k*DATA_W +: DATA_W] = im[DATA_W-1] ? (~im + DATA_W'(1)) : im;

    assign a = a_q[k*DATA_W +: DATA_W];
    assign b = b_q[k*DATA_W +: DATA_W];
    assign mx_d[k*DATA_W +: DATA_W] = (a >= b) ? a : b;
    assign mn_d[k*DATA_W +: DATA_W] = (a >= b) ? b : a;

    assign mxe = MAG_W'(mx_q[k*DATA_W +: DATA_W]);
    assign mne = MAG_W'(mn_q[k*DATA_W +: DATA_W]);
    always_comb begin
      mag = mxe;
      case (mode2_q)
        2'b00:   mag = mxe + (mne >> 1);
        2'b01:   mag = mxe + (mne >> 2);
        2'b10:   mag = mxe + mne;
        default: mag = mxe;
      endcase
    end
    assign mag_d[k*MAG_W +: MAG_W] = mag;
  end

  // Beat 0 seeds the running peak; afterwards only a strictly larger lane replaces it.
  always_comb begin
    best_mag = run_mag_q;
    best_idx = run_idx_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (((cnt_q == '0) && (k == 0)) || (out_mag_q[k*MAG_W +: MAG_W] > best_mag)) begin
        best_mag = out_mag_q[k*MAG_W +: MAG_W];
        best_idx = IDX_W'(cnt_q) * IDX_W'(NUM_CH) + IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      mode1_q   <= 2'b00;
      mode2_q   <= 2'b00;
      a_q       <= '0;
      b_q       <= '0;
      mx_q      <= '0;
      mn_q      <= '0;
      out_mag_q <= '0;
    end else if (en) begin
      v1_q      <= in_valid;
      mode1_q   <= mode;
      a_q       <= a_d;
      b_q       <= b_d;
      v2_q      <= v1_q;
      mode2_q   <= mode1_q;
      mx_q      <= mx_d;
      mn_q      <= mn_d;
      v3_q      <= v2_q;
      out_mag_q <= mag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      run_mag_q    <= '0;
      run_idx_q    <= '0;
      peak_mag_q   <= '0;
      peak_idx_q   <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= 1'b0;
      if (hs_out) begin
        cnt_q     <= out_last ? '0 : cnt_q + CNT_W'(1);
        run_mag_q <= best_mag;
        run_idx_q <= best_idx;
        if (out_last) begin
          peak_mag_q   <= best_mag;
          peak_idx_q   <= best_idx;
          peak_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_mag_stream.sv
`default_nettype none
// Directed bench for fft_mag_stream (DATA_W=12, NUM_CH=2, FRAME_LEN=4).
module tb_fft_mag_stream;

  localparam int DW = 12;
  localparam int MW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [47:0]   in_data;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [25:0]   out_mag;
  logic          out_last;
  logic          peak_valid;
  logic [12:0]   peak_mag;
  logic [2:0]    peak_idx;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         re0, im0, re1, im1;
    logic [1:0] md;
    int         e0, e1;
  } vec_t;

  vec_t vecs[8];
  vec_t fr[8];
  vec_t bp[3];

  fft_mag_stream #(.DATA_W(DW), .NUM_CH(2), .FRAME_LEN(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_mag(out_mag), .out_last(out_last), .peak_valid(peak_valid),
    .peak_mag(peak_mag), .peak_idx(peak_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_data = {DW'(v.im1), DW'(v.re1), DW'(v.im0), DW'(v.re0)};
    mode    = v.md;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic int lane(input int k);
    return int'(out_mag[k*MW +: MW]);
  endfunction

  initial begin
    vecs[0] = '{-3, -2, -1, -2, 2'b00, 4, 2};
    vecs[1] = '{22, 68, 78, 243, 2'b00, 79, 282};
    vecs[2] = '{22, 68, 0, 0, 2'b01, 73, 0};
    vecs[3] = '{22, 68, -2048, -2048, 2'b10, 90, 4096};
    vecs[4] = '{22, 68, -2048, -2048, 2'b11, 68, 2048};
    vecs[5] = '{-2048, -2048, 2047, -2048, 2'b00, 3072, 3071};
    vecs[6] = '{-2048, -2048, 100, -7, 2'b01, 2560, 101};
    vecs[7] = '{2047, 2047, 0, -1, 2'b10, 4094, 1};

    fr[0] = '{100, 0, 50, 0, 2'b11, 100, 50};
    fr[1] = '{200, 0, 499, 0, 2'b11, 200, 499};
    fr[2] = '{10, 0, 500, 0, 2'b11, 10, 500};
    fr[3] = '{500, 0, 3, 0, 2'b11, 500, 3};
    fr[4] = '{1000, 0, 0, 0, 2'b11, 1000, 0};
    fr[5] = '{0, 0, 0, 0, 2'b11, 0, 0};
    fr[6] = '{0, 0, 0, 0, 2'b11, 0, 0};
    fr[7] = '{7, 0, 1000, 0, 2'b11, 7, 1000};

    // Mode changes on every beat to show it travels with the data.
    bp[0] = '{10, 5, 0, 0, 2'b11, 10, 0};
    bp[1] = '{1, 200, 0, 0, 2'b10, 201, 0};
    bp[2] = '{-300, 4, 0, 0, 2'b00, 302, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; mode = 2'b00;
    tick(); tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_mag", int'(out_mag), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_peak_valid", int'(peak_valid), 0);
    chk("rst_peak_mag", int'(peak_mag), 0);
    chk("rst_peak_idx", int'(peak_idx), 0);
    rst = 1'b0;

    // Single beats: latency and arithmetic per mode.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_early", i), int'(out_valid), 0);
      tick();
      chk($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("vec%0d_lane0", i), lane(0), vecs[i].e0);
      chk($sformatf("vec%0d_lane1", i), lane(1), vecs[i].e1);
      tick();
    end

    // Backpressure with three beats in flight.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(bp[i]);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready_low", int'(in_ready), 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_hold%0d", c), lane(0), bp[0].e0);
      chk($sformatf("bp_hold_ready%0d", c), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_beat%0d_valid", i), int'(out_valid), 1);
      chk($sformatf("bp_beat%0d_mag", i), lane(0), bp[i].e0);
      tick();
    end
    chk("bp_drained", int'(out_valid), 0);

    // Two back-to-back frames: tie handling and no cross-frame corruption.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(fr[i]);
      in_valid = 1'b1;
      tick();
      if (i == 4) begin
        chk("fr_b2_last", int'(out_last), 0);
        chk("fr_b2_lane1", lane(1), 500);
      end
      if (i == 5) begin
        chk("fr_b3_last", int'(out_last), 1);
        chk("fr_b3_lane0", lane(0), 500);
        chk("fr_b3_pv", int'(peak_valid), 0);
      end
      if (i == 6) begin
        chk("fr1_peak_valid", int'(peak_valid), 1);
        chk("fr1_peak_mag", int'(peak_mag), 500);
        chk("fr1_peak_idx", int'(peak_idx), 5);
        chk("fr2_b0_lane0", lane(0), 1000);
      end
      if (i == 7) begin
        chk("fr1_pulse_end", int'(peak_valid), 0);
        chk("fr1_peak_hold", int'(peak_mag), 500);
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("fr2_last", int'(out_last), 1);
    tick();
    chk("fr2_peak_valid", int'(peak_valid), 1);
    chk("fr2_peak_mag", int'(peak_mag), 1000);
    chk("fr2_peak_idx", int'(peak_idx), 0);

    // Reset in the middle of a frame.
    do_reset();
    begin
      vec_t p0, p1;
      vec_t nf[4];
      int nb, lastb, seen;
      p0 = '{2000, 0, 0, 0, 2'b11, 2000, 0};
      p1 = '{1500, 0, 0, 0, 2'b11, 1500, 0};
      nf[0] = '{5, 0, 6, 0, 2'b11, 5, 6};
      nf[1] = '{7, 0, 3, 0, 2'b11, 7, 3};
      nf[2] = '{2, 0, 1, 0, 2'b11, 2, 1};
      nf[3] = '{8, 0, 4, 0, 2'b11, 8, 4};
      drive(p0); in_valid = 1'b1; tick();
      drive(p1); tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_out_mag", int'(out_mag), 0);
      chk("mid_rst_in_ready", int'(in_ready), 1);
      rst = 1'b0;
      nb = 0; lastb = -1; seen = 0;
      for (int c = 0; c < 24 && seen == 0; c++) begin
        if (c < 4) begin
          drive(nf[c]);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (out_last) lastb = nb;
          nb++;
        end
        tick();
        if (peak_valid) seen = 1;
      end
      chk("mid_peak_seen", seen, 1);
      chk("mid_beats", nb, 4);
      chk("mid_last_beat", lastb, 3);
      chk("mid_peak_mag", int'(peak_mag), 8);
      chk("mid_peak_idx", int'(peak_idx), 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_mag_stream.md
FFT_MAG_STREAM -- requirements
Module: fft_mag_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12: signed two's-complement width of each I and Q component.
REQ-002 The block SHALL have parameter NUM_CH, default 2: complex lanes per beat.
REQ-003 The block SHALL have parameter FRAME_LEN, default 256: beats per FFT frame, at least 2.
REQ-004 The block SHALL have derived widths MAG_W = DATA_W+1 and IDX_W = clog2(FRAME_LEN*NUM_CH).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port rst, input, 1: reset.
REQ-008 Port in_valid, input, 1: input beat valid.
REQ-009 Port in_ready, output, 1: block accepts beat.
REQ-010 Port in_data, input, 2*NUM_CH*DATA_W: lane k re at [2k*DATA_W +: DATA_W], im at [(2k+1)*DATA_W +: DATA_W].
REQ-011 Port mode, input, 2: approximation select, sampled with each accepted beat.
REQ-012 Port out_valid, output, 1: output beat valid.
REQ-013 Port out_ready, input, 1: downstream accepts beat.
REQ-014 Port out_mag, output, NUM_CH*MAG_W: lane k unsigned at [k*MAG_W +: MAG_W].
REQ-015 Port out_last, output, 1: qualifies the final beat of a frame.
REQ-016 Port peak_valid, output, 1: one-cycle pulse at frame end.
REQ-017 Port peak_mag, output, MAG_W: largest frame magnitude.
REQ-018 Port peak_idx, output, IDX_W: bin index of peak_mag, = beat*NUM_CH + lane.

Function
REQ-019 Per lane, a = |re| and b = |im|; |-2^(DATA_W-1)| SHALL equal 2^(DATA_W-1), exact with no wrap.
REQ-020 With mx = max(a,b) and mn = min(a,b): mode 00 -> mx + (mn>>1); 01 -> mx + (mn>>2); 10 -> a + b; 11 -> mx.
REQ-021 Results SHALL be exact in MAG_W bits, with no saturation or truncation beyond the listed shifts.
REQ-022 The pipeline SHALL have three register stages (abs, max/min, sum); latency is 3 cycles from the input handshake to out_valid when out_ready is held high.
REQ-023 Mode SHALL travel with its beat; a mode change mid-stream affects only beats accepted after the change.
REQ-024 The pipeline SHALL advance only when en = !out_valid | out_ready, and in_ready SHALL equal en.
REQ-025 A beat is accepted on in_valid & in_ready.
REQ-026 While out_valid=1 and out_ready=0, out_mag, out_last and all in-flight data SHALL hold stable; no beat is dropped or duplicated.
REQ-027 The output beat counter SHALL increment on each output handshake and wrap from FRAME_LEN-1 to 0.
REQ-028 out_last SHALL equal (count == FRAME_LEN-1) & out_valid.
REQ-029 The peak tracker SHALL update on each output handshake.
REQ-030 Beat 0 of a frame SHALL load the running peak unconditionally from that beat.
REQ-031 On later beats, a lane SHALL replace the running peak only if its magnitude is strictly greater (ties keep the lower index; within a beat the lower lane wins).
REQ-032 The cycle after the handshake of the out_last beat, peak_valid SHALL be 1 for exactly one cycle.
REQ-033 peak_mag and peak_idx SHALL be registered at frame end, include the last beat, and hold until the next frame end.
REQ-034 Continuous streaming with no bubble SHALL be supported; the peak of frame N SHALL NOT be corrupted by beat 0 of frame N+1 in the same cycle.

Reset
REQ-035 While rst=1 at a clk edge: all stage valids, out_valid, out_last and peak_valid SHALL become 0.
REQ-036 While rst=1 at a clk edge: the beat counter, running peak, peak_mag, peak_idx and out_mag SHALL become 0.
REQ-037 While rst=1, in_ready SHALL be 1 (pipeline empty).
REQ-038 Reset mid-frame SHALL discard in-flight beats and the partial peak; the next accepted beat is beat 0 of a new frame.

Verification
REQ-039 Scenario, DATA_W=12, NUM_CH=2, mode 00: lanes (-3,-2),(-1,-2) -> out_mag 4, 2 exactly 3 cycles after acceptance.
REQ-040 Scenario, lane (22,68) in modes 00/01/10/11 -> 79/73/90/68; lane (78,243) in mode 00 -> 282.
REQ-041 Scenario, lane (-2048,-2048): mode 10 -> 4096; mode 00 -> 3072; mode 11 -> 2048; no wrap.
REQ-042 Scenario, 3 beats in flight, out_ready low 5 cycles -> in_ready low, out_mag stable, then all 3 beats delivered in order.
REQ-043 Scenario, FRAME_LEN=4: max 500 at beat 2 lane 1, tie 500 at beat 3 lane 0 -> out_last on beat 3, then peak_valid one cycle later with peak_mag=500 and peak_idx=5.
REQ-044 Scenario, rst for 1 cycle after 2 beats of a frame -> outputs zero; the next 4 beats form a full frame with a correct peak.
